fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of the PC and the instruction-memory address.
REQ-002 Parameter INST_WIDTH, default 32: instruction width.
REQ-003 Parameter IMEM_DEPTH, default 1024: number of instruction-memory words; the PC wraps modulo this value.
REQ-004 Parameter RESET_PC, default 0: PC value after reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port imem_addr, output, ADDR_WIDTH bits: word index presented to the instruction memory.
REQ-008 Port imem_instr, input, INST_WIDTH bits: instruction word returned combinationally in the same cycle as imem_addr.
REQ-009 Port redirect_valid, input, 1 bit: branch or jump taken; this is the flush request.
REQ-010 Port redirect_pc, input, ADDR_WIDTH bits: target word index.
REQ-011 Port out_valid, output, 1 bit: the IF/ID register holds a valid instruction.
REQ-012 Port out_ready, input, 1 bit: decode accepts this cycle.
REQ-013 Port out_instr, output, INST_WIDTH bits: registered instruction.
REQ-014 Port out_pc, output, ADDR_WIDTH bits: word index of out_instr.
REQ-015 Port halted, output, 1 bit: asserted while in HALT.

Function
REQ-016 The PC SHALL be a word index: sequential fetch adds 1, and the result wraps from IMEM_DEPTH-1 to 0.
REQ-017 imem_addr SHALL equal the current PC register combinationally.
REQ-018 The FSM SHALL have states BOOT, RUN and HALT.
- BOOT lasts exactly one cycle after reset release and then goes to RUN.
- BOOT produces no fetch: out_valid stays 0.
REQ-019 In RUN, a fetch SHALL occur in a cycle when (!out_valid || out_ready) and redirect_valid=0.
- On a fetch: out_instr<=imem_instr, out_pc<=PC, out_valid<=1, PC<=PC+1.
- Fetch-to-output latency is one cycle.
REQ-020 In RUN, when no fetch occurs and out_ready=1, out_valid SHALL go to 0. When out_ready=0, all output registers and the PC SHALL hold.
REQ-021 redirect_valid SHALL have priority over stall, fetch and HALT in every state except BOOT.
- On redirect: PC<=redirect_pc modulo IMEM_DEPTH, out_valid<=0, state<=RUN.
- The target is fetched in the following cycle.
REQ-022 A redirect asserted during BOOT SHALL be applied, and the FSM still enters RUN.
REQ-023 When a fetch captures EBREAK (0x00100073), the FSM SHALL go to HALT.
- The EBREAK itself is delivered with out_valid=1.
- The PC does not advance past it.
REQ-024 In HALT, no fetch SHALL occur; out_valid clears once the pending word is accepted; only a redirect leaves HALT.

Reset
REQ-025 During rst, the outputs SHALL take these values:
- PC=RESET_PC, state=BOOT.
- out_valid=0, out_instr=0, out_pc=0, halted=0.
- Performance counters are 0.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL discard all pending state immediately, without waiting for a clock edge.

Configuration
REQ-027 Macro FETCH_PERF_CNT_EN SHALL control the performance counters.
- Defined: two 32-bit output ports are added, perf_fetched (count of fetches) and perf_bubbles (count of RUN cycles with out_valid=0).
- Both counters saturate at 0xFFFFFFFF.
- Undefined: the ports and counters are absent and the remaining behaviour is identical.

Structure
REQ-028 Shared package fetch_pkg SHALL hold the following:
- the FSM state enum (BOOT, RUN, HALT);
- INSTR_EBREAK=0x00100073;
- INSTR_NOP=0x00000013.
REQ-029 PC next-value selection and wrap logic SHALL be a sub-module named fetch_pc_gen. It contains no other logic.

Verification
REQ-030 Reset, then out_ready=1, memory[0..3] loaded:
- out_valid first rises 2 cycles after reset release, with out_pc=0.
- out_pc then reads 0, 1, 2, 3 on consecutive cycles.
REQ-031 out_ready=0 for 3 cycles while out_pc=5:
- out_pc, out_instr and imem_addr=6 all hold.
- On release, out_pc=6 follows in the next cycle.
REQ-032 redirect_valid=1, redirect_pc=21 while out_ready=0:
- Next cycle: out_valid=0 and imem_addr=21.
- The cycle after: out_pc=21.
REQ-033 PC=1023, IMEM_DEPTH=1024: after out_pc=1023, the next out_pc is 0.
REQ-034 memory[8]=0x00100073:
- out_pc=8 is valid and halted=1; afterwards, out_valid=0 and imem_addr stays 9.
- redirect_pc=0 leaves HALT and out_pc=0 follows.
REQ-035 Compile with FETCH_PERF_CNT_EN, then run 10 fetches plus 2 redirects: perf_fetched=10 and perf_bubbles equals the observed count of RUN cycles with out_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect request and IF/ID handshake.
interface fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [INST_WIDTH-1:0] imem_instr;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [INST_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic                  halted;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, halted,
        input  imem_instr, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, halted,
        output imem_instr, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Next-PC selection: redirect target (modulo depth) beats sequential advance, else hold.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int IMEM_DEPTH = 1024
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] pc_next
);
    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(IMEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(IMEM_DEPTH - 1);

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_pc % DEPTH;
        end else if (advance) begin
            pc_next = (pc == LAST) ? '0 : pc + ADDR_WIDTH'(1);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch with IF/ID register, redirect flush and EBREAK halt.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_bubbles counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);
    fetch_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic                  fetch;
    logic                  is_ebreak;
    logic                  valid_q;
    logic [INST_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0] out_pc_q;

    assign is_ebreak = (bus.imem_instr == INST_WIDTH'(INSTR_EBREAK));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (fetch && is_ebreak) state_next = HALT;
            HALT:    if (bus.redirect_valid) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // A redirect suppresses the fetch, which keeps it ahead of stall and halt.
    always_comb begin
        fetch      = (state == RUN) && !bus.redirect_valid && (!valid_q || bus.out_ready);
        bus.halted = (state == HALT);
    end

    fetch_pc_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_pc_gen (
        .pc             (pc),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .advance        (fetch),
        .pc_next        (pc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            instr_q  <= '0;
            out_pc_q <= '0;
        end else if (fetch) begin
            valid_q  <= 1'b1;
            instr_q  <= bus.imem_instr;
            out_pc_q <= pc;
        end else if (bus.redirect_valid || bus.out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_pc    = out_pc_q;

`ifdef FETCH_PERF_CNT_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (fetch && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((state == RUN) && !valid_q && (perf_bubbles != '1)) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a cycle-level reference model of the fetch rules.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fetch_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bif ();
    logic [31:0] mem [DEPTH];

    int          m_pc, m_outpc;
    bit          m_valid, m_boot, m_halt;
    logic [31:0] m_instr;
    longint      m_fetched, m_bubbles;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    always #5 clk = ~clk;

    assign bif.imem_instr = mem[bif.imem_addr[9:0]];

    fetch_unit #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'd0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bif)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
`endif
    );

    task automatic model_reset();
        m_pc = 0; m_outpc = 0; m_valid = 0; m_boot = 1; m_halt = 0;
        m_instr = 0; m_fetched = 0; m_bubbles = 0;
    endtask

    // Advance one clock: the model applies the fetch rules to the inputs seen at the edge.
    task automatic step();
        bit bubble;
        int target;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            bubble = !m_boot && !m_halt && !m_valid;
            target = int'(bif.redirect_pc % 32'd1024);
            if (m_boot) begin
                if (bif.redirect_valid) m_pc = target;
                m_boot = 0;
            end else if (bif.redirect_valid) begin
                m_pc = target; m_valid = 0; m_halt = 0;
            end else if (m_halt) begin
                if (bif.out_ready) m_valid = 0;
            end else if (!m_valid || bif.out_ready) begin
                m_instr = mem[m_pc];
                m_outpc = m_pc;
                m_valid = 1;
                if (m_fetched < 64'hFFFF_FFFF) m_fetched++;
                if (m_instr == INSTR_EBREAK) m_halt = 1;
                m_pc = (m_pc + 1) % DEPTH;
            end
            if (bubble && m_bubbles < 64'hFFFF_FFFF) m_bubbles++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bif.out_ready = 1'b1; bif.redirect_valid = 1'b0; bif.redirect_pc = '0;
        step(); step();
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", bif.out_valid); end
        checks++; if (bif.out_instr !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr: got %0h expected 0", bif.out_instr); end
        checks++; if (bif.out_pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_out_pc: got %0d expected 0", bif.out_pc); end
        checks++; if (bif.halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %0b expected 0", bif.halted); end
        checks++; if (bif.imem_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc: got %0d expected 0", bif.imem_addr); end
        rst = 1'b0;
        step();
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL boot_no_fetch: got valid=%0b expected 0", bif.out_valid); end
        step();
        checks++; if ({bif.out_valid, bif.out_pc} !== {1'b1, 32'd0}) begin errors++; $display("[TB] FAIL first_fetch: got valid=%0b pc=%0d expected valid=1 pc=0", bif.out_valid, bif.out_pc); end
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({bif.out_valid, bif.out_pc, bif.out_instr} !== {1'b1, 32'(k), mem[k]}) begin
                errors++; $display("[TB] FAIL seq_%0d: got valid=%0b pc=%0d instr=%0h expected valid=1 pc=%0d instr=%0h", k, bif.out_valid, bif.out_pc, bif.out_instr, k, mem[k]);
            end
        end
    endtask

    task automatic test_stall();
        step(); step();
        checks++; if (bif.out_pc !== 32'd5) begin errors++; $display("[TB] FAIL stall_setup: got pc=%0d expected 5", bif.out_pc); end
        bif.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({bif.out_valid, bif.out_pc, bif.out_instr, bif.imem_addr} !== {1'b1, 32'd5, mem[5], 32'd6}) begin
                errors++; $display("[TB] FAIL stall_hold_%0d: got valid=%0b pc=%0d instr=%0h addr=%0d expected 1/5/%0h/6", k, bif.out_valid, bif.out_pc, bif.out_instr, bif.imem_addr, mem[5]);
            end
        end
        bif.out_ready = 1'b1;
        step();
        checks++; if ({bif.out_valid, bif.out_pc} !== {1'b1, 32'd6}) begin errors++; $display("[TB] FAIL stall_release: got valid=%0b pc=%0d expected valid=1 pc=6", bif.out_valid, bif.out_pc); end
    endtask

    task automatic test_redirect();
        bif.out_ready = 1'b0; bif.redirect_valid = 1'b1; bif.redirect_pc = 32'd21;
        step();
        checks++; if ({bif.out_valid, bif.imem_addr} !== {1'b0, 32'd21}) begin errors++; $display("[TB] FAIL redirect_flush: got valid=%0b addr=%0d expected valid=0 addr=21", bif.out_valid, bif.imem_addr); end
        bif.redirect_valid = 1'b0; bif.out_ready = 1'b1;
        step();
        checks++; if ({bif.out_valid, bif.out_pc, bif.out_instr} !== {1'b1, 32'd21, mem[21]}) begin errors++; $display("[TB] FAIL redirect_target: got valid=%0b pc=%0d instr=%0h expected pc=21 instr=%0h", bif.out_valid, bif.out_pc, bif.out_instr, mem[21]); end
        bif.redirect_valid = 1'b1; bif.redirect_pc = 32'd1054;
        step();
        checks++; if (bif.imem_addr !== 32'd30) begin errors++; $display("[TB] FAIL redirect_modulo: got addr=%0d expected 30", bif.imem_addr); end
        bif.redirect_valid = 1'b0;
        step();
        checks++; if ({bif.out_valid, bif.out_pc} !== {1'b1, 32'd30}) begin errors++; $display("[TB] FAIL redirect_modulo_fetch: got valid=%0b pc=%0d expected valid=1 pc=30", bif.out_valid, bif.out_pc); end
    endtask

    task automatic test_wrap();
        int expected [3] = '{1022, 1023, 0};
        bif.redirect_valid = 1'b1; bif.redirect_pc = 32'd1022;
        step();
        bif.redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({bif.out_valid, bif.out_pc} !== {1'b1, 32'(expected[k])}) begin
                errors++; $display("[TB] FAIL wrap_%0d: got valid=%0b pc=%0d expected valid=1 pc=%0d", k, bif.out_valid, bif.out_pc, expected[k]);
            end
        end
    endtask

    task automatic test_halt();
        bif.redirect_valid = 1'b1; bif.redirect_pc = 32'd7;
        step();
        bif.redirect_valid = 1'b0;
        step(); step();
        checks++; if ({bif.out_valid, bif.halted, bif.out_pc, bif.out_instr} !== {1'b1, 1'b1, 32'd8, INSTR_EBREAK}) begin errors++; $display("[TB] FAIL halt_ebreak: got valid=%0b halted=%0b pc=%0d instr=%0h expected 1/1/8/00100073", bif.out_valid, bif.halted, bif.out_pc, bif.out_instr); end
        bif.out_ready = 1'b0;
        step();
        checks++; if ({bif.out_valid, bif.halted} !== 2'b11) begin errors++; $display("[TB] FAIL halt_pending: got valid=%0b halted=%0b expected 1/1", bif.out_valid, bif.halted); end
        bif.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({bif.out_valid, bif.halted, bif.imem_addr} !== {1'b0, 1'b1, 32'd9}) begin
                errors++; $display("[TB] FAIL halt_idle_%0d: got valid=%0b halted=%0b addr=%0d expected 0/1/9", k, bif.out_valid, bif.halted, bif.imem_addr);
            end
        end
        bif.redirect_valid = 1'b1; bif.redirect_pc = 32'd0;
        step();
        checks++; if ({bif.out_valid, bif.halted, bif.imem_addr} !== {1'b0, 1'b0, 32'd0}) begin errors++; $display("[TB] FAIL halt_exit: got valid=%0b halted=%0b addr=%0d expected 0/0/0", bif.out_valid, bif.halted, bif.imem_addr); end
        bif.redirect_valid = 1'b0;
        step();
        checks++; if ({bif.out_valid, bif.out_pc, bif.out_instr} !== {1'b1, 32'd0, mem[0]}) begin errors++; $display("[TB] FAIL halt_resume: got valid=%0b pc=%0d instr=%0h expected 1/0/%0h", bif.out_valid, bif.out_pc, bif.out_instr, mem[0]); end
    endtask

    task automatic test_boot_redirect();
        rst = 1'b1;
        #2;
        checks++; if ({bif.out_valid, bif.imem_addr} !== {1'b0, 32'd0}) begin errors++; $display("[TB] FAIL pulse_reset: got valid=%0b addr=%0d expected 0/0", bif.out_valid, bif.imem_addr); end
        rst = 1'b0;
        model_reset();
        bif.redirect_valid = 1'b1; bif.redirect_pc = 32'd40;
        step();
        checks++; if ({bif.out_valid, bif.halted, bif.imem_addr} !== {1'b0, 1'b0, 32'd40}) begin errors++; $display("[TB] FAIL boot_redirect: got valid=%0b halted=%0b addr=%0d expected 0/0/40", bif.out_valid, bif.halted, bif.imem_addr); end
        bif.redirect_valid = 1'b0;
        step();
        checks++; if ({bif.out_valid, bif.out_pc} !== {1'b1, 32'd40}) begin errors++; $display("[TB] FAIL boot_redirect_fetch: got valid=%0b pc=%0d expected 1/40", bif.out_valid, bif.out_pc); end
    endtask

    task automatic test_async_reset();
        bif.out_ready = 1'b0;
        step(); step();
        bif.redirect_valid = 1'b1; bif.redirect_pc = 32'd99;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({bif.out_valid, bif.halted, bif.out_pc, bif.out_instr, bif.imem_addr} !== {1'b0, 1'b0, 32'd0, 32'd0, 32'd0}) begin
            errors++; $display("[TB] FAIL async_reset: got valid=%0b halted=%0b pc=%0d instr=%0h addr=%0d expected all zero", bif.out_valid, bif.halted, bif.out_pc, bif.out_instr, bif.imem_addr);
        end
        bif.redirect_valid = 1'b0; bif.out_ready = 1'b1;
        step();
        #2;
        rst = 1'b0;
        step();
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_boot: got valid=%0b expected 0", bif.out_valid); end
        step();
        checks++; if ({bif.out_valid, bif.out_pc} !== {1'b1, 32'd0}) begin errors++; $display("[TB] FAIL async_restart: got valid=%0b pc=%0d expected 1/0", bif.out_valid, bif.out_pc); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        int observed;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        bif.out_ready = 1'b1; bif.redirect_valid = 1'b1; bif.redirect_pc = 32'd200;
        step();
        observed = 0;
        for (int c = 1; c <= 12; c++) begin
            if (!bif.out_valid && !bif.halted) observed++;
            bif.redirect_valid = (c == 4) || (c == 8);
            bif.redirect_pc    = (c == 4) ? 32'd300 : 32'd400;
            step();
        end
        bif.redirect_valid = 1'b0;
        checks++; if (perf_fetched !== 32'd10) begin errors++; $display("[TB] FAIL perf_fetched: got %0d expected 10", perf_fetched); end
        checks++; if (perf_bubbles !== 32'(observed)) begin errors++; $display("[TB] FAIL perf_bubbles: got %0d expected %0d", perf_bubbles, observed); end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 6; k++) mem[$urandom_range(0, DEPTH - 1)] = INSTR_EBREAK;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bif.out_ready      = ($urandom_range(0, 9) < 7);
            bif.redirect_valid = ($urandom_range(0, 15) == 0);
            bif.redirect_pc    = $urandom;
            step();
            checks++;
            if ({bif.out_valid, bif.halted, bif.out_pc, bif.out_instr, bif.imem_addr} !==
                {m_valid, m_halt, 32'(m_outpc), m_instr, 32'(m_pc)}) begin
                errors++;
                $display("[TB] FAIL random_%0d: got valid=%0b halted=%0b pc=%0d instr=%0h addr=%0d expected valid=%0b halted=%0b pc=%0d instr=%0h addr=%0d",
                         cyc, bif.out_valid, bif.halted, bif.out_pc, bif.out_instr, bif.imem_addr,
                         m_valid, m_halt, m_outpc, m_instr, m_pc);
            end
`ifdef FETCH_PERF_CNT_EN
            checks++;
            if ({perf_fetched, perf_bubbles} !== {32'(m_fetched), 32'(m_bubbles)}) begin
                errors++; $display("[TB] FAIL random_perf_%0d: got fetched=%0d bubbles=%0d expected %0d/%0d", cyc, perf_fetched, perf_bubbles, m_fetched, m_bubbles);
            end
`endif
        end
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            do w = $urandom; while (w == INSTR_EBREAK);
            mem[i] = w;
        end
        mem[2] = INSTR_NOP;
        mem[8] = INSTR_EBREAK;
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_boot_redirect();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
